// File: rtl/ula_operand_sequencer_pkg.sv
// ula_operand_sequencer_pkg
//   Shared definitions for the ULA operand sequencer and the ULA itself.
//   - S_*  : sequencer state codes, also driven out on PHASE for the LEDG display.
//   - OP_* : 3-bit ULA opcode encodings; OP_MAX is the highest legal opcode.
//   - op_valid() : true when an opcode falls inside the legal range.
package ula_operand_sequencer_pkg;

    localparam logic [1:0] S_WAIT_A  = 2'd0;
    localparam logic [1:0] S_WAIT_B  = 2'd1;
    localparam logic [1:0] S_WAIT_OP = 2'd2;
    localparam logic [1:0] S_READY   = 2'd3;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_MAX = 3'b101;

    function automatic logic op_valid(input logic [2:0] op);
        return op <= OP_MAX;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// key_debouncer
//   Cleans up one raw active-low pushbutton and emits a single-cycle pulse per press.
//   Ports:
//     CLOCK_50 - system clock
//     RESET_N  - asynchronous active-low reset (released synchronously by the parent)
//     key_n    - raw key, active-low, asynchronous to CLOCK_50
//     press    - one-cycle pulse on a debounced high->low transition
//   A 2-FF synchronizer feeds a stability counter; the debounced level only flips after
//   DEBOUNCE_CYCLES consecutive samples disagree with it. The press pulse is registered after
//   an edge-detect stage so the press-to-capture latency is DEBOUNCE_CYCLES+3 edges.
module key_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    input  logic key_n,
    output logic press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic          level_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        // Any sample matching the current level restarts the stability count.
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        press_d = level_prev_q & ~level_q;
    end

    // Idle-high reset: a key held through reset is seen as a fresh press once debounced.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q       <= 2'b11;
            level_q      <= 1'b1;
            level_prev_q <= 1'b1;
            cnt_q        <= '0;
            press_q      <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], key_n};
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
            press_q      <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/ula_operand_sequencer.sv
// ula_operand_sequencer
//   Collects operand A, operand B and an opcode from the switches in three ENTER-confirmed steps
//   and holds them registered and stable for the combinational ULA.
//   Ports:
//     CLOCK_50    - system clock
//     RESET_N     - asynchronous active-low reset
//     SW_DATA     - operand switches, sampled in the capture cycle
//     SW_OP       - opcode switches, sampled in the capture cycle
//     KEY_ENTER_N - raw ENTER pushbutton, active-low
//     KEY_CLEAR_N - raw CLEAR pushbutton, active-low
//     OPERAND_A   - captured operand A
//     OPERAND_B   - captured operand B
//     OPCODE      - captured opcode
//     READY       - high while A, B and OPCODE are all valid
//     PHASE       - current state code
//     OP_ERR      - sticky flag: the last opcode capture was rejected
module ula_operand_sequencer
    import ula_operand_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] SW_DATA,
    input  logic [2:0]       SW_OP,
    input  logic             KEY_ENTER_N,
    input  logic             KEY_CLEAR_N,
    output logic [WIDTH-1:0] OPERAND_A,
    output logic [WIDTH-1:0] OPERAND_B,
    output logic [2:0]       OPCODE,
    output logic             READY,
    output logic [1:0]       PHASE,
    output logic             OP_ERR
);

    // Reset asserts immediately but releases on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    logic enter_press;
    logic clear_press;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_enter_db (
        .CLOCK_50(CLOCK_50),
        .RESET_N (rst_n),
        .key_n   (KEY_ENTER_N),
        .press   (enter_press)
    );

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_clear_db (
        .CLOCK_50(CLOCK_50),
        .RESET_N (rst_n),
        .key_n   (KEY_CLEAR_N),
        .press   (clear_press)
    );

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [2:0]       opc_q, opc_d;
    logic             err_q, err_d;

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        opc_d   = opc_q;
        err_d   = err_q;
        // Clear has priority; a simultaneous enter is dropped.
        if (clear_press) begin
            state_d = S_WAIT_A;
            opa_d   = '0;
            opb_d   = '0;
            opc_d   = '0;
            err_d   = 1'b0;
        end else if (enter_press) begin
            unique case (state_q)
                S_WAIT_A: begin
                    opa_d   = SW_DATA;
                    state_d = S_WAIT_B;
                end
                S_WAIT_B: begin
                    opb_d   = SW_DATA;
                    state_d = S_WAIT_OP;
                end
                S_WAIT_OP: begin
                    if (op_valid(SW_OP)) begin
                        opc_d   = SW_OP;
                        err_d   = 1'b0;
                        state_d = S_READY;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                S_READY: begin
                    // New A starts a fresh entry; B and OPCODE stay until overwritten.
                    opa_d   = SW_DATA;
                    state_d = S_WAIT_B;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT_A;
            opa_q   <= '0;
            opb_q   <= '0;
            opc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            opc_q   <= opc_d;
            err_q   <= err_d;
        end
    end

    assign OPERAND_A = opa_q;
    assign OPERAND_B = opb_q;
    assign OPCODE    = opc_q;
    assign READY     = (state_q == S_READY);
    assign PHASE     = state_q;
    assign OP_ERR    = err_q;

endmodule

// File: tb/tb_ula_operand_sequencer.sv
// tb_ula_operand_sequencer
//   Directed bench for ula_operand_sequencer with DEBOUNCE_CYCLES=4, WIDTH=4.
module tb_ula_operand_sequencer;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw_data;
    logic [2:0] sw_op;
    logic       key_enter_n;
    logic       key_clear_n;
    logic [3:0] operand_a;
    logic [3:0] operand_b;
    logic [2:0] opcode;
    logic       ready;
    logic [1:0] phase;
    logic       op_err;

    int checks   = 0;
    int failures = 0;

    ula_operand_sequencer #(
        .WIDTH          (4),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .CLOCK_50   (clk),
        .RESET_N    (rst_n),
        .SW_DATA    (sw_data),
        .SW_OP      (sw_op),
        .KEY_ENTER_N(key_enter_n),
        .KEY_CLEAR_N(key_clear_n),
        .OPERAND_A  (operand_a),
        .OPERAND_B  (operand_b),
        .OPCODE     (opcode),
        .READY      (ready),
        .PHASE      (phase),
        .OP_ERR     (op_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Press one or both keys cleanly, hold well past the debounce latency, release and settle.
    task automatic press(input logic en, input logic cl);
        @(negedge clk);
        if (en) key_enter_n = 1'b0;
        if (cl) key_clear_n = 1'b0;
        repeat (12) @(negedge clk);
        key_enter_n = 1'b1;
        key_clear_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    // Press ENTER and count rising edges until PHASE moves; edge t counts as 1, so the
    // capture edge t+7 must be count 8.
    task automatic press_timed(input string name);
        logic [1:0] old;
        int lat;
        old = phase;
        lat = 0;
        @(negedge clk);
        key_enter_n = 1'b0;
        while (lat < 30 && phase === old) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat !== 8) begin
            failures++;
            $display("FAIL %s: capture after %0d edges, want 8", name, lat);
        end
        @(negedge clk);
        key_enter_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        key_enter_n = 1'b1;
        key_clear_n = 1'b1;
        sw_data     = 4'd0;
        sw_op       = 3'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({operand_a, operand_b, opcode, ready, phase, op_err} !== 16'h0) begin
            failures++;
            $display("FAIL reset_outputs: got a=%0d b=%0d op=%0d rdy=%0b ph=%0d err=%0b want all 0",
                     operand_a, operand_b, opcode, ready, phase, op_err);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (phase !== 2'd0) begin
            failures++;
            $display("FAIL reset_release_phase: got %0d want 0", phase);
        end
    endtask

    task automatic test_full_entry();
        sw_data = 4'b0011;
        press_timed("lat_a");
        sw_data = 4'b0101;
        press_timed("lat_b");
        sw_op = 3'b010;
        press_timed("lat_op");
        checks++;
        if (operand_a !== 4'd3) begin
            failures++;
            $display("FAIL full_a: got %0d want 3", operand_a);
        end
        checks++;
        if (operand_b !== 4'd5) begin
            failures++;
            $display("FAIL full_b: got %0d want 5", operand_b);
        end
        checks++;
        if (opcode !== 3'b010) begin
            failures++;
            $display("FAIL full_op: got %0d want 2", opcode);
        end
        checks++;
        if (ready !== 1'b1 || phase !== 2'd3) begin
            failures++;
            $display("FAIL full_ready: got rdy=%0b ph=%0d want rdy=1 ph=3", ready, phase);
        end
    endtask

    task automatic test_re_entry();
        sw_data = 4'b1001;
        press(1'b1, 1'b0);
        checks++;
        if (operand_a !== 4'd9 || operand_b !== 4'd5 || opcode !== 3'b010) begin
            failures++;
            $display("FAIL reentry_regs: got a=%0d b=%0d op=%0d want a=9 b=5 op=2",
                     operand_a, operand_b, opcode);
        end
        checks++;
        if (ready !== 1'b0 || phase !== 2'd1) begin
            failures++;
            $display("FAIL reentry_phase: got rdy=%0b ph=%0d want rdy=0 ph=1", ready, phase);
        end
    endtask

    task automatic test_bounce();
        press(1'b0, 1'b1);
        checks++;
        if (phase !== 2'd0 || operand_a !== 4'd0 || operand_b !== 4'd0 || opcode !== 3'd0) begin
            failures++;
            $display("FAIL clear: got ph=%0d a=%0d b=%0d op=%0d want all 0",
                     phase, operand_a, operand_b, opcode);
        end
        sw_data = 4'd7;
        for (int i = 0; i < 5; i++) begin
            key_enter_n = 1'b0;
            repeat (2) @(negedge clk);
            key_enter_n = 1'b1;
            repeat (2) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (phase !== 2'd0 || operand_a !== 4'd0) begin
            failures++;
            $display("FAIL bounce: got ph=%0d a=%0d want ph=0 a=0", phase, operand_a);
        end
        key_enter_n = 1'b0;
        repeat (3) @(negedge clk);
        key_enter_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (phase !== 2'd0 || operand_a !== 4'd0) begin
            failures++;
            $display("FAIL glitch: got ph=%0d a=%0d want ph=0 a=0", phase, operand_a);
        end
    endtask

    task automatic test_bad_opcode();
        sw_data = 4'd1;
        press(1'b1, 1'b0);
        sw_data = 4'd2;
        press(1'b1, 1'b0);
        sw_op = 3'b111;
        press(1'b1, 1'b0);
        checks++;
        if (op_err !== 1'b1 || opcode !== 3'd0 || phase !== 2'd2) begin
            failures++;
            $display("FAIL bad_op: got err=%0b op=%0d ph=%0d want err=1 op=0 ph=2",
                     op_err, opcode, phase);
        end
        sw_op = 3'b001;
        press(1'b1, 1'b0);
        checks++;
        if (op_err !== 1'b0 || opcode !== 3'b001 || ready !== 1'b1) begin
            failures++;
            $display("FAIL good_op: got err=%0b op=%0d rdy=%0b want err=0 op=1 rdy=1",
                     op_err, opcode, ready);
        end
    endtask

    task automatic test_clear_collision();
        press(1'b0, 1'b1);
        sw_data = 4'd4;
        press(1'b1, 1'b0);
        checks++;
        if (phase !== 2'd1 || operand_a !== 4'd4) begin
            failures++;
            $display("FAIL pre_collision: got ph=%0d a=%0d want ph=1 a=4", phase, operand_a);
        end
        press(1'b1, 1'b1);
        checks++;
        if (phase !== 2'd0 || operand_a !== 4'd0 || operand_b !== 4'd0 || opcode !== 3'd0) begin
            failures++;
            $display("FAIL collision: got ph=%0d a=%0d b=%0d op=%0d want all 0",
                     phase, operand_a, operand_b, opcode);
        end
        sw_data = 4'd6;
        @(negedge clk);
        key_enter_n = 1'b0;
        repeat (100) @(negedge clk);
        key_enter_n = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if (phase !== 2'd1 || operand_a !== 4'd6 || operand_b !== 4'd0) begin
            failures++;
            $display("FAIL held_key: got ph=%0d a=%0d b=%0d want ph=1 a=6 b=0",
                     phase, operand_a, operand_b);
        end
    endtask

    task automatic test_reset_mid_run();
        sw_data = 4'd8;
        press(1'b1, 1'b0);
        sw_op = 3'b101;
        press(1'b1, 1'b0);
        checks++;
        if (ready !== 1'b1 || opcode !== 3'b101 || operand_b !== 4'd8) begin
            failures++;
            $display("FAIL pre_reset: got rdy=%0b op=%0d b=%0d want rdy=1 op=5 b=8",
                     ready, opcode, operand_b);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({operand_a, operand_b, opcode, ready, phase, op_err} !== 16'h0) begin
            failures++;
            $display("FAIL async_reset: got a=%0d b=%0d op=%0d rdy=%0b ph=%0d err=%0b want all 0",
                     operand_a, operand_b, opcode, ready, phase, op_err);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_full_entry();
        test_re_entry();
        test_bounce();
        test_bad_opcode();
        test_clear_collision();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
